bcd_to_bin_seq: RTL

Sequential BCD-to-binary converter for the display path. It converts a signed 4-digit BCD value (sign plus thousands, hundreds, tens and units digits) back into a DW-bit two's-complement word, using reverse double-dabble with one shift per clock. It accepts the same digit/sign format the binary-to-display path produces, so a value can be round-tripped. It also flags invalid digits and out-of-range magnitudes.

---
 rtl/bcd_to_bin_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential signed 4-digit BCD to two's-complement converter
module bcd_to_bin_seq #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_start,
  input  logic          in_Signo,
  input  logic [15:0]   in_digits,
  output logic [DW-1:0] out_Bin,
  output logic          out_busy,
  output logic          out_done,
  output logic          out_error
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Largest positive magnitude; a negative result may reach one more than this.
  localparam logic [31:0] POS_MAX = 32'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic [3:0]  LAST_IT = 4'd13;

  state_t       state, state_n;
  logic [15:0]  bcd;
  logic [13:0]  bin;
  logic [3:0]   cnt;
  logic         sign;
  logic         dig_err;
  logic         err_wait;

  logic         digits_bad;
  logic [29:0]  sh;
  logic [15:0]  bcd_corr;
  logic [31:0]  mag32;
  logic [DW-1:0] mag_dw;
  logic         range_err;
  logic         res_err;
  logic [DW-1:0] res_val;
  logic         finish;

  // Flag any incoming nibble above 9 so a bad request skips the shifting entirely.
  always_comb begin
    digits_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_digits[i*4 +: 4] > 4'd9) digits_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull every nibble >= 8 down by 3.
  always_comb begin
    sh       = {bcd, bin} >> 1;
    bcd_corr = sh[29:14];
    for (int i = 0; i < 4; i++) begin
      if (sh[14 + i*4 +: 4] >= 4'd8) bcd_corr[i*4 +: 4] = sh[14 + i*4 +: 4] - 4'd3;
    end
  end

  // Range check and sign application on the accumulated magnitude.
  always_comb begin
    mag32     = {18'd0, bin};
    mag_dw    = mag32[DW-1:0];
    range_err = sign ? (mag32 > POS_MAX + 32'd1) : (mag32 > POS_MAX);
    res_err   = dig_err | range_err;
    res_val   = sign ? (~mag_dw + 1'b1) : mag_dw;
    // A digit error lingers one extra cycle in DONE so its pulse lands two edges after start.
    finish    = (state == DONE) && !(dig_err && !err_wait);
  end

  // Next-state decision.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_start) state_n = digits_bad ? DONE : SHIFT;
      SHIFT:   if (cnt == LAST_IT) state_n = DONE;
      DONE:    if (finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bcd       <= '0;
      bin       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      dig_err   <= 1'b0;
      err_wait  <= 1'b0;
      out_Bin   <= '0;
      out_busy  <= 1'b0;
      out_done  <= 1'b0;
      out_error <= 1'b0;
    end else begin
      state    <= state_n;
      out_busy <= (state_n != IDLE);
      out_done <= finish;
      case (state)
        IDLE: begin
          if (in_start) begin
            bcd      <= in_digits;
            sign     <= in_Signo;
            bin      <= '0;
            cnt      <= '0;
            dig_err  <= digits_bad;
            err_wait <= 1'b0;
          end
        end
        SHIFT: begin
          bcd <= bcd_corr;
          bin <= sh[13:0];
          cnt <= cnt + 4'd1;
        end
        DONE: begin
          err_wait <= 1'b1;
          if (finish) begin
            out_error <= res_err;
            out_Bin   <= res_err ? '0 : res_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
